// File: rtl/ram_port_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ram_arb_pkg
//  Description : Shared types and default sizing for the two-port block RAM
//                arbiter (state encoding, RAM command record, defaults).
//  Revision    : 1.0 - initial release
// ============================================================================
package ram_arb_pkg;

  localparam int c_def_ram_addr_bits   = 13;
  localparam int c_def_ram_width       = 8;
  localparam int c_def_max_lock_cycles = 64;

  // Arbitration state: free-for-all, or owned by one requester under lock.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_t;

  // One RAM command at the default geometry.
  typedef struct packed {
    logic                           we;
    logic [c_def_ram_addr_bits-1:0] addr;
    logic [c_def_ram_width-1:0]     wdata;
  } ram_cmd_t;

endpackage : ram_arb_pkg
`default_nettype wire

// File: rtl/ram_port_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : ram_port_arbiter_if
//  Description : Bundle of both requester ports and the block RAM port.
//                slave  = the arbiter's view, master = requesters + RAM.
//  Revision    : 1.0 - initial release
// ============================================================================
interface ram_port_arbiter_if
  import ram_arb_pkg::*;
#(
  parameter int RAM_ADDR_BITS = c_def_ram_addr_bits,
  parameter int RAM_WIDTH     = c_def_ram_width
);

  logic                     req0, req1;
  logic                     we0, we1;
  logic [RAM_ADDR_BITS-1:0] addr0, addr1;
  logic [RAM_WIDTH-1:0]     wdata0, wdata1;
  logic                     lock0, lock1;
  logic                     gnt0, gnt1;
  logic                     rvalid0, rvalid1;
  logic [RAM_WIDTH-1:0]     rdata0, rdata1;
  logic                     ram_en, ram_we;
  logic [RAM_ADDR_BITS-1:0] ram_addr;
  logic [RAM_WIDTH-1:0]     ram_wdata;
  logic [RAM_WIDTH-1:0]     ram_rdata;
  logic                     arb_bsy;

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, lock0, lock1,
    input  ram_rdata,
    output gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1,
    output ram_en, ram_we, ram_addr, ram_wdata, arb_bsy
  );

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, lock0, lock1,
    output ram_rdata,
    input  gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1,
    input  ram_en, ram_we, ram_addr, ram_wdata, arb_bsy
  );

endinterface : ram_port_arbiter_if
`default_nettype wire

// File: rtl/ram_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : ram_port_arbiter
//  Description : Two-requester arbiter for a single block RAM port.
//                Round-robin when free, burst ownership via lock with a
//                starvation limit, registered RAM command, tagged read return.
//  Revision    : 1.0 - initial release
// ============================================================================
module ram_port_arbiter
  import ram_arb_pkg::*;
#(
  parameter int RAM_ADDR_BITS   = c_def_ram_addr_bits,
  parameter int RAM_WIDTH       = c_def_ram_width,
  parameter int MAX_LOCK_CYCLES = c_def_max_lock_cycles
) (
  input  wire logic         clk,
  input  wire logic         rst_n_sync,
  ram_port_arbiter_if.slave bus
);

  localparam int                CNT_W      = $clog2(MAX_LOCK_CYCLES + 1);
  localparam logic [CNT_W-1:0]  c_lock_max = CNT_W'(MAX_LOCK_CYCLES);
  localparam logic [CNT_W-1:0]  c_cnt_one  = CNT_W'(1);

  typedef struct packed {
    logic                     we;
    logic [RAM_ADDR_BITS-1:0] addr;
    logic [RAM_WIDTH-1:0]     wdata;
  } cmd_t;

  arb_state_t               state_q, state_d;
  logic                     last_gnt_q, last_gnt_d;   // 1 = requester 1 granted last
  logic [CNT_W-1:0]         lock_cnt_q, lock_cnt_d;
  logic                     gnt0, gnt1, gnt_any;
  cmd_t                     sel_cmd;

  logic                     ram_en_q, ram_we_q;
  logic [RAM_ADDR_BITS-1:0] ram_addr_q;
  logic [RAM_WIDTH-1:0]     ram_wdata_q;
  logic                     rd_pend_q, rd_tag_q;
  logic                     rvalid0_q, rvalid1_q;

  // Arbitration state register.
  always_ff @(posedge clk or negedge rst_n_sync) begin
    if (!rst_n_sync) begin
      state_q    <= IDLE;
      last_gnt_q <= 1'b1;
      lock_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      last_gnt_q <= last_gnt_d;
      lock_cnt_q <= lock_cnt_d;
    end
  end

  // Grant decision and next arbitration state. The grant that opens a locked
  // burst counts toward the limit when the other side is already waiting, so
  // the waiter sees at most MAX_LOCK_CYCLES grants go by.
  always_comb begin
    gnt0       = 1'b0;
    gnt1       = 1'b0;
    state_d    = state_q;
    last_gnt_d = last_gnt_q;
    lock_cnt_d = lock_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (bus.req0 && (!bus.req1 || last_gnt_q)) gnt0 = 1'b1;
        else if (bus.req1)                          gnt1 = 1'b1;
        if (gnt0 && bus.lock0 && (CNT_W'(bus.req1) != c_lock_max)) begin
          state_d    = OWN0;
          lock_cnt_d = CNT_W'(bus.req1);
        end
        if (gnt1 && bus.lock1 && (CNT_W'(bus.req0) != c_lock_max)) begin
          state_d    = OWN1;
          lock_cnt_d = CNT_W'(bus.req0);
        end
      end
      OWN0: begin
        gnt0 = bus.req0;
        if (gnt0) begin
          if (!bus.lock0 || (bus.req1 && (lock_cnt_q + c_cnt_one == c_lock_max))) begin
            state_d    = IDLE;
            lock_cnt_d = '0;
          end else if (bus.req1) begin
            lock_cnt_d = lock_cnt_q + c_cnt_one;
          end
        end else if (!bus.lock0) begin
          state_d    = IDLE;
          lock_cnt_d = '0;
        end
      end
      OWN1: begin
        gnt1 = bus.req1;
        if (gnt1) begin
          if (!bus.lock1 || (bus.req0 && (lock_cnt_q + c_cnt_one == c_lock_max))) begin
            state_d    = IDLE;
            lock_cnt_d = '0;
          end else if (bus.req0) begin
            lock_cnt_d = lock_cnt_q + c_cnt_one;
          end
        end else if (!bus.lock1) begin
          state_d    = IDLE;
          lock_cnt_d = '0;
        end
      end
      default: begin
        state_d    = IDLE;
        lock_cnt_d = '0;
      end
    endcase
    if (gnt0) last_gnt_d = 1'b0;
    if (gnt1) last_gnt_d = 1'b1;
  end

  assign gnt_any = gnt0 | gnt1;
  assign sel_cmd = gnt1 ? cmd_t'{we: bus.we1, addr: bus.addr1, wdata: bus.wdata1}
                        : cmd_t'{we: bus.we0, addr: bus.addr0, wdata: bus.wdata0};

  // RAM command register and read-owner tag pipeline (grant -> RAM -> rvalid).
  always_ff @(posedge clk or negedge rst_n_sync) begin
    if (!rst_n_sync) begin
      ram_en_q    <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      rd_pend_q   <= 1'b0;
      rd_tag_q    <= 1'b0;
      rvalid0_q   <= 1'b0;
      rvalid1_q   <= 1'b0;
    end else begin
      ram_en_q  <= gnt_any;
      ram_we_q  <= gnt_any & sel_cmd.we;
      rd_pend_q <= gnt_any & ~sel_cmd.we;
      if (gnt_any) begin
        ram_addr_q  <= sel_cmd.addr;
        ram_wdata_q <= sel_cmd.wdata;
        rd_tag_q    <= gnt1;
      end
      rvalid0_q <= rd_pend_q & ~rd_tag_q;
      rvalid1_q <= rd_pend_q &  rd_tag_q;
    end
  end

  // Grants are forced low while reset is asserted so every output reads 0.
  assign bus.gnt0      = gnt0 & rst_n_sync;
  assign bus.gnt1      = gnt1 & rst_n_sync;
  assign bus.ram_en    = ram_en_q;
  assign bus.ram_we    = ram_we_q;
  assign bus.ram_addr  = ram_addr_q;
  assign bus.ram_wdata = ram_wdata_q;
  assign bus.rvalid0   = rvalid0_q;
  assign bus.rvalid1   = rvalid1_q;
  // Read data is the shared RAM output, masked to zero outside a return cycle.
  assign bus.rdata0    = (rvalid0_q | rvalid1_q) ? bus.ram_rdata : '0;
  assign bus.rdata1    = (rvalid0_q | rvalid1_q) ? bus.ram_rdata : '0;
  assign bus.arb_bsy   = ram_en_q | rvalid0_q | rvalid1_q;

endmodule : ram_port_arbiter
`default_nettype wire

// File: tb/tb_ram_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ram_port_arbiter
//  Description : Self-checking bench for ram_port_arbiter: vector table,
//                hand sequences for lock / reset corners, read scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ram_port_arbiter;
  import ram_arb_pkg::*;

  localparam int AW = 13;
  localparam int DW = 8;

  logic clk        = 1'b0;
  logic rst_n_sync = 1'b0;
  always #5 clk = ~clk;

  ram_port_arbiter_if #(.RAM_ADDR_BITS(AW), .RAM_WIDTH(DW)) bus ();
  ram_port_arbiter_if #(.RAM_ADDR_BITS(AW), .RAM_WIDTH(DW)) bus4 ();

  ram_port_arbiter #(.RAM_ADDR_BITS(AW), .RAM_WIDTH(DW), .MAX_LOCK_CYCLES(64)) u_dut (
    .clk(clk), .rst_n_sync(rst_n_sync), .bus(bus));

  ram_port_arbiter #(.RAM_ADDR_BITS(AW), .RAM_WIDTH(DW), .MAX_LOCK_CYCLES(4)) u_dut4 (
    .clk(clk), .rst_n_sync(rst_n_sync), .bus(bus4));

  assign bus4.ram_rdata = '0;

  int chk = 0;
  int err = 0;

  function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
    return DW'(a) ^ DW'(8'h5A);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk++;
    if (act !== exp) begin
      err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Block RAM model: read-first, one cycle latency.
  logic [DW-1:0] ram_mem [int];
  always @(posedge clk) begin
    if (bus.ram_en) begin
      bus.ram_rdata <= ram_mem.exists(int'(bus.ram_addr)) ? ram_mem[int'(bus.ram_addr)]
                                                          : init_val(bus.ram_addr);
      if (bus.ram_we) ram_mem[int'(bus.ram_addr)] = bus.ram_wdata;
    end
  end

  // Scoreboard: expected read returns queued at grant, compared at rvalid.
  typedef struct {
    logic          tag;
    logic [DW-1:0] data;
  } rd_exp_t;
  rd_exp_t       sb[$];
  logic [DW-1:0] shadow [int];

  function automatic logic [DW-1:0] shadow_rd(input logic [AW-1:0] a);
    return shadow.exists(int'(a)) ? shadow[int'(a)] : init_val(a);
  endfunction

  always @(negedge clk) begin
    rd_exp_t e;
    if (!rst_n_sync) begin
      sb.delete();
    end else begin
      check("gnt_onehot", 32'(bus.gnt0 & bus.gnt1), 0);
      if (bus.gnt0) begin
        if (bus.we0) shadow[int'(bus.addr0)] = bus.wdata0;
        else         sb.push_back('{1'b0, shadow_rd(bus.addr0)});
      end
      if (bus.gnt1) begin
        if (bus.we1) shadow[int'(bus.addr1)] = bus.wdata1;
        else         sb.push_back('{1'b1, shadow_rd(bus.addr1)});
      end
      if (!bus.ram_en) check("ram_we_idle", 32'(bus.ram_we), 0);
      if (bus.rvalid0 || bus.rvalid1) begin
        check("rvalid_onehot", 32'(bus.rvalid0 & bus.rvalid1), 0);
        if (sb.size() == 0) begin
          check("rvalid_unexpected", 1, 0);
        end else begin
          e = sb.pop_front();
          check("rvalid_tag", 32'(bus.rvalid1), 32'(e.tag));
          check("rdata", 32'(bus.rvalid1 ? bus.rdata1 : bus.rdata0), 32'(e.data));
        end
      end
    end
  end

  typedef struct {
    logic r0; logic w0; logic [AW-1:0] a0; logic [DW-1:0] d0; logic l0;
    logic r1; logic w1; logic [AW-1:0] a1; logic [DW-1:0] d1; logic l1;
    logic eg0; logic eg1;
  } vec_t;
  vec_t tbl[$];

  function automatic vec_t mk(input logic r0, w0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                              input logic l0, r1, w1, input logic [AW-1:0] a1,
                              input logic [DW-1:0] d1, input logic l1, eg0, eg1);
    vec_t v;
    v = '{r0, w0, a0, d0, l0, r1, w1, a1, d1, l1, eg0, eg1};
    return v;
  endfunction

  task automatic idle_inputs();
    bus.req0 = 0; bus.we0 = 0; bus.addr0 = '0; bus.wdata0 = '0; bus.lock0 = 0;
    bus.req1 = 0; bus.we1 = 0; bus.addr1 = '0; bus.wdata1 = '0; bus.lock1 = 0;
    bus4.req0 = 0; bus4.we0 = 0; bus4.addr0 = '0; bus4.wdata0 = '0; bus4.lock0 = 0;
    bus4.req1 = 0; bus4.we1 = 0; bus4.addr1 = '0; bus4.wdata1 = '0; bus4.lock1 = 0;
  endtask

  task automatic drive(input vec_t v);
    bus.req0 = v.r0; bus.we0 = v.w0; bus.addr0 = v.a0; bus.wdata0 = v.d0; bus.lock0 = v.l0;
    bus.req1 = v.r1; bus.we1 = v.w1; bus.addr1 = v.a1; bus.wdata1 = v.d1; bus.lock1 = v.l1;
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_gnt0"},    32'(bus.gnt0),    0);
    check({tag, "_gnt1"},    32'(bus.gnt1),    0);
    check({tag, "_ram_en"},  32'(bus.ram_en),  0);
    check({tag, "_ram_we"},  32'(bus.ram_we),  0);
    check({tag, "_addr"},    32'(bus.ram_addr), 0);
    check({tag, "_wdata"},   32'(bus.ram_wdata), 0);
    check({tag, "_rvalid"},  32'({bus.rvalid1, bus.rvalid0}), 0);
    check({tag, "_rdata"},   32'({bus.rdata1, bus.rdata0}), 0);
    check({tag, "_bsy"},     32'(bus.arb_bsy), 0);
  endtask

  initial begin
    #200000;
    err++;
    $display("FAIL watchdog: got timeout expected finish");
    $display("CHECKS %0d ERRORS %0d", chk, err);
    $finish;
  end

  initial begin
    logic exp4 [10];
    idle_inputs();

    // Reset state, with requests present to show grants are held low.
    bus.req0 = 1; bus.req1 = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    next_cyc();
    bus.req0 = 0; bus.req1 = 0;
    rst_n_sync = 1;

    // Lock limit of 4 on the second instance: 0 x4, 1, then 0 resumes.
    exp4 = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
    bus4.req0 = 1; bus4.lock0 = 1; bus4.req1 = 1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check($sformatf("lim4_c%0d_gnt0", i), 32'(bus4.gnt0), 32'(!exp4[i]));
      check($sformatf("lim4_c%0d_gnt1", i), 32'(bus4.gnt1), 32'(exp4[i]));
      next_cyc();
    end
    idle_inputs();
    next_cyc();

    // Single read: grant N, RAM command N+1, return N+2.
    bus.req0 = 1; bus.we0 = 0; bus.addr0 = 13'h0123;
    @(negedge clk);
    check("rd_gnt0", 32'(bus.gnt0), 1);
    next_cyc();
    bus.req0 = 0;
    @(negedge clk);
    check("rd_ram_en",   32'(bus.ram_en),   1);
    check("rd_ram_we",   32'(bus.ram_we),   0);
    check("rd_ram_addr", 32'(bus.ram_addr), 32'h0123);
    check("rd_bsy",      32'(bus.arb_bsy),  1);
    check("rd_early",    32'(bus.rvalid0),  0);
    next_cyc();
    @(negedge clk);
    check("rd_rvalid0", 32'(bus.rvalid0), 1);
    check("rd_rvalid1", 32'(bus.rvalid1), 0);
    check("rd_rdata0",  32'(bus.rdata0),  32'h79);
    next_cyc();

    // Fresh reset, then the vector table starting at reset release.
    rst_n_sync = 0;
    repeat (2) next_cyc();
    tbl.push_back(mk(1, 0, 13'h0010, 8'h00, 0, 1, 0, 13'h0020, 8'h00, 0, 1, 0));
    tbl.push_back(mk(1, 0, 13'h0010, 8'h00, 0, 1, 0, 13'h0020, 8'h00, 0, 0, 1));
    tbl.push_back(mk(1, 0, 13'h0010, 8'h00, 0, 1, 0, 13'h0020, 8'h00, 0, 1, 0));
    tbl.push_back(mk(1, 0, 13'h0010, 8'h00, 0, 1, 0, 13'h0020, 8'h00, 0, 0, 1));
    tbl.push_back(mk(0, 0, 13'h0000, 8'h00, 0, 1, 1, 13'h1FFF, 8'hA5, 0, 0, 1));
    tbl.push_back(mk(1, 0, 13'h1FFF, 8'h00, 0, 0, 0, 13'h0000, 8'h00, 0, 1, 0));
    tbl.push_back(mk(0, 0, 13'h0000, 8'h00, 0, 0, 0, 13'h0000, 8'h00, 0, 0, 0));
    tbl.push_back(mk(0, 0, 13'h0000, 8'h00, 0, 1, 0, 13'h1FFF, 8'h00, 0, 0, 1));
    tbl.push_back(mk(1, 1, 13'h0030, 8'h11, 1, 1, 0, 13'h0030, 8'h00, 0, 1, 0));
    tbl.push_back(mk(1, 0, 13'h0030, 8'h00, 1, 1, 0, 13'h0030, 8'h00, 0, 1, 0));
    tbl.push_back(mk(0, 0, 13'h0000, 8'h00, 0, 1, 0, 13'h0030, 8'h00, 0, 0, 0));
    tbl.push_back(mk(0, 0, 13'h0000, 8'h00, 0, 1, 0, 13'h0030, 8'h00, 0, 0, 1));
    tbl.push_back(mk(0, 0, 13'h0000, 8'h00, 0, 0, 0, 13'h0000, 8'h00, 0, 0, 0));
    drive(tbl[0]);
    rst_n_sync = 1;
    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i]);
      @(negedge clk);
      check($sformatf("vec%0d_gnt0", i), 32'(bus.gnt0), 32'(tbl[i].eg0));
      check($sformatf("vec%0d_gnt1", i), 32'(bus.gnt1), 32'(tbl[i].eg1));
      next_cyc();
    end
    idle_inputs();
    repeat (3) next_cyc();

    // Locked 10-write burst by requester 1 while requester 0 waits.
    bus.req0 = 1; bus.addr0 = 13'h0040;
    @(negedge clk);
    check("burst_pre_gnt0", 32'(bus.gnt0), 1);
    next_cyc();
    bus.addr0 = 13'h1005;
    for (int i = 0; i < 10; i++) begin
      bus.req1 = 1; bus.we1 = 1; bus.addr1 = 13'h1000 + AW'(i);
      bus.wdata1 = 8'hC0 + DW'(i); bus.lock1 = (i < 9);
      @(negedge clk);
      check($sformatf("burst%0d_gnt1", i), 32'(bus.gnt1), 1);
      check($sformatf("burst%0d_gnt0", i), 32'(bus.gnt0), 0);
      next_cyc();
    end
    bus.req1 = 0; bus.lock1 = 0;
    @(negedge clk);
    check("burst_post_gnt0", 32'(bus.gnt0), 1);
    next_cyc();
    idle_inputs();
    repeat (3) next_cyc();

    // Reset in the cycle after a read grant drops the read.
    bus.req0 = 1; bus.addr0 = 13'h0050;
    @(negedge clk);
    check("rst_rd_gnt0", 32'(bus.gnt0), 1);
    next_cyc();
    bus.req0 = 0;
    #2;
    rst_n_sync = 0;
    bus.req0 = 1; bus.we0 = 1; bus.addr0 = 13'h0060; bus.wdata0 = 8'h01;
    bus.req1 = 1; bus.we1 = 1; bus.addr1 = 13'h0061; bus.wdata1 = 8'h02;
    @(negedge clk);
    check_all_zero("midrst");
    next_cyc();
    rst_n_sync = 1;
    @(negedge clk);
    check("post_rst_gnt0", 32'(bus.gnt0), 1);
    check("post_rst_gnt1", 32'(bus.gnt1), 0);
    next_cyc();
    idle_inputs();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("post_rst_rv%0d", i), 32'({bus.rvalid1, bus.rvalid0}), 0);
      next_cyc();
    end

    check("sb_empty", 32'(sb.size()), 0);
    $display("CHECKS %0d ERRORS %0d", chk, err);
    $finish;
  end

endmodule : tb_ram_port_arbiter
`default_nettype wire
